// File: rtl/bowl_roll_scorer_if.sv
// Result bus between the bowling roll scorer and its neighbours.
// Carries the upstream random value into the scorer and the roll/score
// results out to the score display stage.
//   master : the scorer itself (consumes rand_in, drives the results)
//   slave  : the surrounding system (drives rand_in, observes the results)
interface bowl_roll_scorer_if #(
   parameter int RAND_W = 3
) ();
   logic [RAND_W-1:0] rand_in;
   logic [3:0]        last_knock;
   logic [3:0]        pins_left;
   logic [3:0]        frame_num;
   logic [1:0]        roll_idx;
   logic [8:0]        total_score;
   logic              strike;
   logic              spare;
   logic              roll_done;
   logic              game_over;

   modport master (
      input  rand_in,
      output last_knock, pins_left, frame_num, roll_idx, total_score,
             strike, spare, roll_done, game_over
   );

   modport slave (
      output rand_in,
      input  last_knock, pins_left, frame_num, roll_idx, total_score,
             strike, spare, roll_done, game_over
   );
endinterface

// File: rtl/bowl_roll_scorer.sv
// Ten-pin bowling roll scorer.
// Turns each debounced throw press into a pin knockdown derived from the
// upstream random value, tracks frame/roll/pins and keeps a running score
// with strike/spare bonuses and frame-10 fill balls.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   KEY[0]   : synchronous active-low reset
//   KEY[1]   : throw button, active-low, asynchronous to CLOCK_50
//   bus      : rand_in in; last_knock, pins_left, frame_num, roll_idx,
//              total_score, strike, spare, roll_done, game_over out
//
// state | meaning
// ------+-----------------------------------------------------------
// WAIT  | idle, waiting for a throw press
// CALC  | rand_in captured; roll is applied on the next edge
// DONE  | final roll scored; presses ignored until reset
module bowl_roll_scorer #(
   parameter int RAND_W     = 3,
   parameter int KNOCK_BASE = 4,
   parameter int STRIKE_MIN = 6
) (
   input  logic               CLOCK_50,
   input  logic [1:0]         KEY,
   bowl_roll_scorer_if.master bus
);

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic sync1_q, sync2_q, sync2_dly_q, press_q;

   logic [RAND_W-1:0] rand_q, rand_d;
   logic [3:0]        last_knock_q, last_knock_d;
   logic [3:0]        pins_q, pins_d;
   logic [3:0]        frame_q, frame_d;
   logic [1:0]        roll_q, roll_d;
   logic [8:0]        score_q, score_d;
   logic              strike_q, strike_d;
   logic              spare_q, spare_d;
   logic              done_q, done_d;
   logic              over_q, over_d;
   logic [1:0]        b1_q, b1_d;
   logic              b2_q, b2_d;

   logic [4:0] r_ext, knock_raw, pins_ext, knock5;
   logic [3:0] knock;
   logic [4:0] roll_pts;
   logic       cleared, is_strike, is_spare, last_frame;

   // Knockdown for the captured value against the standing pins.
   always_comb begin
      r_ext     = 5'(rand_q);
      pins_ext  = {1'b0, pins_q};
      knock_raw = r_ext + 5'(KNOCK_BASE);
      if (r_ext >= 5'(STRIKE_MIN)) begin
         knock5 = pins_ext;
      end else if (knock_raw < pins_ext) begin
         knock5 = knock_raw;
      end else begin
         knock5 = pins_ext;
      end
      knock      = knock5[3:0];
      cleared    = (knock == pins_q);
      // A strike needs a fresh rack; clearing a partial rack on roll 1 is a spare.
      is_strike  = cleared && (pins_q == 4'd10);
      is_spare   = cleared && (roll_q == 2'd1) && (pins_q != 4'd10);
      last_frame = (frame_q == 4'd10);
      // b1 counts pending bonus credits from earlier strikes/spares.
      roll_pts   = 5'(knock) * (5'd1 + 5'(b1_q));
   end

   always_comb begin
      state_d      = state_q;
      rand_d       = rand_q;
      last_knock_d = last_knock_q;
      pins_d       = pins_q;
      frame_d      = frame_q;
      roll_d       = roll_q;
      score_d      = score_q;
      strike_d     = strike_q;
      spare_d      = spare_q;
      done_d       = 1'b0;
      over_d       = over_q;
      b1_d         = b1_q;
      b2_d         = b2_q;

      unique case (state_q)
         ST_WAIT: begin
            if (press_q) begin
               rand_d  = bus.rand_in;
               state_d = ST_CALC;
            end
         end

         ST_CALC: begin
            state_d      = ST_WAIT;
            done_d       = 1'b1;
            last_knock_d = knock;
            score_d      = score_q + 9'(roll_pts);
            strike_d     = is_strike;
            spare_d      = is_spare;

            if (!last_frame) begin
               b1_d = 2'(b2_q) + 2'(is_strike) + 2'(is_spare);
               b2_d = is_strike;
               if (roll_q == 2'd0 && !is_strike) begin
                  roll_d = 2'd1;
                  pins_d = pins_q - knock;
               end else begin
                  frame_d = frame_q + 4'd1;
                  roll_d  = 2'd0;
                  pins_d  = 4'd10;
               end
            end else begin
               b1_d   = 2'(b2_q);
               b2_d   = 1'b0;
               pins_d = cleared ? 4'd10 : (pins_q - knock);
               case (roll_q)
                  2'd0: roll_d = 2'd1;
                  2'd1: begin
                     // strike_q still holds roll 0's strike flag here.
                     if (strike_q || cleared) begin
                        roll_d = 2'd2;
                     end else begin
                        over_d  = 1'b1;
                        state_d = ST_DONE;
                     end
                  end
                  default: begin
                     over_d  = 1'b1;
                     state_d = ST_DONE;
                  end
               endcase
            end
         end

         ST_DONE: state_d = ST_DONE;

         default: state_d = ST_WAIT;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!KEY[0]) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         sync2_dly_q  <= 1'b1;
         press_q      <= 1'b0;
         state_q      <= ST_WAIT;
         rand_q       <= '0;
         last_knock_q <= 4'd0;
         pins_q       <= 4'd10;
         frame_q      <= 4'd1;
         roll_q       <= 2'd0;
         score_q      <= 9'd0;
         strike_q     <= 1'b0;
         spare_q      <= 1'b0;
         done_q       <= 1'b0;
         over_q       <= 1'b0;
         b1_q         <= 2'd0;
         b2_q         <= 1'b0;
      end else begin
         sync1_q      <= KEY[1];
         sync2_q      <= sync1_q;
         sync2_dly_q  <= sync2_q;
         press_q      <= sync2_dly_q & ~sync2_q;
         state_q      <= state_d;
         rand_q       <= rand_d;
         last_knock_q <= last_knock_d;
         pins_q       <= pins_d;
         frame_q      <= frame_d;
         roll_q       <= roll_d;
         score_q      <= score_d;
         strike_q     <= strike_d;
         spare_q      <= spare_d;
         done_q       <= done_d;
         over_q       <= over_d;
         b1_q         <= b1_d;
         b2_q         <= b2_d;
      end
   end

   assign bus.last_knock  = last_knock_q;
   assign bus.pins_left   = pins_q;
   assign bus.frame_num   = frame_q;
   assign bus.roll_idx    = roll_q;
   assign bus.total_score = score_q;
   assign bus.strike      = strike_q;
   assign bus.spare       = spare_q;
   assign bus.roll_done   = done_q;
   assign bus.game_over   = over_q;

endmodule

// File: tb/tb_bowl_roll_scorer.sv
// Bench for bowl_roll_scorer: game-level model (roll list + frame scoring)
// checked against the DUT every cycle, plus literal expectations per scenario.
module tb_bowl_roll_scorer;

   logic       CLOCK_50 = 1'b0;
   logic [1:0] KEY      = 2'b11;

   bowl_roll_scorer_if #(.RAND_W(3)) bus ();

   bowl_roll_scorer #(
      .RAND_W(3), .KNOCK_BASE(4), .STRIKE_MIN(6)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .KEY      (KEY),
      .bus      (bus)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   bit cmp_en = 1'b0;

   // model state
   int rl[0:31];
   int n_rolls;
   int m_frame, m_roll, m_pins, m_score, m_knock;
   int m_strike, m_spare, m_over, m_s0, m_done;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Standard frame-by-frame scoring over the rolls seen so far.
   function automatic int calc_score();
      int s = 0;
      int i = 0;
      for (int f = 1; f <= 10; f++) begin
         if (i >= n_rolls) break;
         if (f == 10) begin
            for (int j = i; j < n_rolls; j++) s += rl[j];
            i = n_rolls;
         end else if (rl[i] == 10) begin
            s += 10;
            if (i + 1 < n_rolls) s += rl[i+1];
            if (i + 2 < n_rolls) s += rl[i+2];
            i += 1;
         end else begin
            s += rl[i];
            if (i + 1 < n_rolls) begin
               s += rl[i+1];
               if (rl[i] + rl[i+1] == 10 && i + 2 < n_rolls) s += rl[i+2];
            end
            i += 2;
         end
      end
      return s;
   endfunction

   task automatic model_reset();
      n_rolls  = 0;
      m_frame  = 1; m_roll = 0; m_pins = 10; m_score = 0; m_knock = 0;
      m_strike = 0; m_spare = 0; m_over = 0; m_s0 = 0; m_done = 0;
      cmp_en   = 1'b1;
   endtask

   task automatic model_roll(input int r);
      int k;
      bit clr;
      k = (r >= 6) ? m_pins : ((r + 4 < m_pins) ? r + 4 : m_pins);
      clr = (k == m_pins);
      rl[n_rolls] = k;
      n_rolls++;
      m_knock  = k;
      m_score  = calc_score();
      m_strike = (clr && m_pins == 10) ? 1 : 0;
      m_spare  = (clr && m_roll == 1 && m_pins != 10) ? 1 : 0;
      if (m_frame < 10) begin
         if (m_roll == 0 && m_strike == 1) begin
            m_frame++; m_pins = 10;
         end else if (m_roll == 0) begin
            m_roll = 1; m_pins -= k;
         end else begin
            m_frame++; m_roll = 0; m_pins = 10;
         end
      end else begin
         m_pins = clr ? 10 : m_pins - k;
         if (m_roll == 0) begin
            m_s0 = m_strike; m_roll = 1;
         end else if (m_roll == 1) begin
            if (m_s0 == 1 || clr) m_roll = 2;
            else m_over = 1;
         end else begin
            m_over = 1;
         end
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge CLOCK_50) begin
      if (cmp_en) begin
         chk("last_knock",  int'(bus.last_knock),  m_knock);
         chk("pins_left",   int'(bus.pins_left),   m_pins);
         chk("frame_num",   int'(bus.frame_num),   m_frame);
         chk("roll_idx",    int'(bus.roll_idx),    m_roll);
         chk("total_score", int'(bus.total_score), m_score);
         chk("strike",      int'(bus.strike),      m_strike);
         chk("spare",       int'(bus.spare),       m_spare);
         chk("roll_done",   int'(bus.roll_done),   m_done);
         chk("game_over",   int'(bus.game_over),   m_over);
         if (bus.roll_done === 1'b1) done_cnt++;
      end
   end

   task automatic do_reset(input int edges, input bit throw_low);
      @(negedge CLOCK_50);
      KEY[0] = 1'b0;
      if (throw_low) KEY[1] = 1'b0;
      repeat (edges) begin
         @(posedge CLOCK_50);
         model_reset();
      end
      @(negedge CLOCK_50);
      KEY = 2'b11;
   endtask

   // E0 is the first edge after KEY[1] drops; results land on E4.
   task automatic press(input int r, input int hold);
      @(negedge CLOCK_50);
      bus.rand_in = 3'(r);
      KEY[1] = 1'b0;
      repeat (5) @(posedge CLOCK_50);
      if (m_over == 0) begin
         model_roll(r);
         m_done = 1;
      end
      @(posedge CLOCK_50);
      m_done = 0;
      repeat (hold - 6) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      KEY[1] = 1'b1;
      repeat (4) @(negedge CLOCK_50);
   endtask

   int d0;

   initial begin
      bus.rand_in = 3'd0;

      // reset and latency
      do_reset(2, 1'b0);
      @(negedge CLOCK_50);
      chk("t1_frame", int'(bus.frame_num), 1);
      chk("t1_pins", int'(bus.pins_left), 10);
      chk("t1_score", int'(bus.total_score), 0);
      chk("t1_over", int'(bus.game_over), 0);
      d0 = done_cnt;
      press(3, 56);
      chk("t1_done_pulses", done_cnt - d0, 1);
      chk("t1_knock", int'(bus.last_knock), 7);
      chk("t1_pins_after", int'(bus.pins_left), 3);
      chk("t1_roll", int'(bus.roll_idx), 1);

      // spare bonus
      do_reset(1, 1'b0);
      press(2, 6);
      press(0, 6);
      chk("t2_spare", int'(bus.spare), 1);
      chk("t2_frame", int'(bus.frame_num), 2);
      chk("t2_score10", int'(bus.total_score), 10);
      press(1, 6);
      chk("t2_score20", int'(bus.total_score), 20);
      press(0, 6);
      chk("t2_score24", int'(bus.total_score), 24);
      chk("t2_frame3", int'(bus.frame_num), 3);
      chk("t2_pins10", int'(bus.pins_left), 10);

      // perfect game
      do_reset(1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         press(7, 6);
         chk("t3_strike", int'(bus.strike), 1);
      end
      chk("t3_score", int'(bus.total_score), 300);
      chk("t3_over", int'(bus.game_over), 1);
      d0 = done_cnt;
      press(7, 6);
      chk("t3_no_roll", done_cnt - d0, 0);
      chk("t3_score_held", int'(bus.total_score), 300);

      // open game
      do_reset(1, 1'b0);
      for (int i = 0; i < 20; i++) press(0, 6);
      chk("t4_score", int'(bus.total_score), 80);
      chk("t4_over", int'(bus.game_over), 1);
      chk("t4_roll", int'(bus.roll_idx), 1);
      chk("t4_frame", int'(bus.frame_num), 10);

      // frame-10 spare fill ball
      do_reset(1, 1'b0);
      for (int i = 0; i < 18; i++) press(0, 6);
      chk("t5_score72", int'(bus.total_score), 72);
      press(2, 6);
      press(0, 6);
      chk("t5_spare", int'(bus.spare), 1);
      chk("t5_roll2", int'(bus.roll_idx), 2);
      chk("t5_pins10", int'(bus.pins_left), 10);
      press(1, 6);
      chk("t5_score87", int'(bus.total_score), 87);
      chk("t5_over", int'(bus.game_over), 1);

      // reset mid-game with the throw button held during reset
      do_reset(1, 1'b0);
      press(2, 6); press(0, 6); press(7, 6); press(1, 6); press(3, 6);
      do_reset(1, 1'b1);
      @(negedge CLOCK_50);
      chk("t6_frame", int'(bus.frame_num), 1);
      chk("t6_roll", int'(bus.roll_idx), 0);
      chk("t6_pins", int'(bus.pins_left), 10);
      chk("t6_score", int'(bus.total_score), 0);
      chk("t6_knock", int'(bus.last_knock), 0);
      d0 = done_cnt;
      repeat (12) @(negedge CLOCK_50);
      chk("t6_no_roll", done_cnt - d0, 0);
      press(3, 6);
      chk("t6_new_knock", int'(bus.last_knock), 7);
      chk("t6_new_score", int'(bus.total_score), 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
